// File: rtl/vlogic_lanes.sv
// Multi-lane pipelined vector logical unit: AND/OR/XOR sub-units with operand and
// result inversion, tail-element masking, valid/ready handshakes and a done pulse.
module vlogic_lanes #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int VL_WIDTH   = 8
) (
    input  logic                        module_clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [2:0]                  op_i,
    input  logic [VL_WIDTH-1:0]         vl_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [LANES*DATA_WIDTH-1:0] a_i,
    input  logic [LANES*DATA_WIDTH-1:0] b_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANES*DATA_WIDTH-1:0] result_o,
    output logic [LANES-1:0]            out_be_o,
    output logic                        out_last_o,
    output logic                        done_o,
    output logic [1:0]                  state_o
);
    // Handshakes: a transfer happens on any cycle where valid and ready are both
    // high; valid never depends on ready, and a raised valid holds its payload.

    localparam int W = LANES * DATA_WIDTH;
    localparam logic [VL_WIDTH-1:0] LANES_VL = VL_WIDTH'(LANES);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FINISH = 2'd2} state_t;
    typedef enum logic [1:0] {U_AND = 2'd0, U_OR = 2'd1, U_XOR = 2'd2} unit_t;

    state_t                state;
    logic [2:0]            op_q;
    logic [VL_WIDTH-1:0]   remain;
    logic [VL_WIDTH-1:0]   step;
    unit_t                 unit_sel;
    unit_t                 out_unit;
    logic                  a_inv;
    logic                  r_inv;
    logic [W-1:0]          a_eff;
    logic [W-1:0]          lane_keep;
    logic [W-1:0]          and_d, or_d, xor_d;
    logic [W-1:0]          and_q, or_q, xor_q;
    logic [LANES-1:0]      be_d, be_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  last_beat;
    logic                  in_fire;
    logic                  out_fire;

    always_comb begin
        unit_sel = U_AND;
        a_inv    = 1'b0;
        r_inv    = 1'b0;
        case (op_q)
            3'b001: r_inv = 1'b1;
            3'b010: a_inv = 1'b1;
            3'b011: unit_sel = U_OR;
            3'b100: begin unit_sel = U_OR; r_inv = 1'b1; end
            3'b101: begin unit_sel = U_OR; a_inv = 1'b1; end
            3'b110: unit_sel = U_XOR;
            3'b111: begin unit_sel = U_XOR; r_inv = 1'b1; end
            default: ;
        endcase
    end

    // Lane k is live while more than k elements remain; on non-final beats
    // remain exceeds LANES so every lane is live.
    always_comb begin
        be_d      = '0;
        lane_keep = '0;
        for (int k = 0; k < LANES; k++) begin
            be_d[k] = (remain > VL_WIDTH'(k));
            lane_keep[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{be_d[k]}};
        end
    end

    assign a_eff = a_inv ? ~a_i : a_i;
    assign and_d = ({W{r_inv}} ^ (a_eff & b_i)) & lane_keep;
    assign or_d  = ({W{r_inv}} ^ (a_eff | b_i)) & lane_keep;
    assign xor_d = ({W{r_inv}} ^ (a_eff ^ b_i)) & lane_keep;

    assign last_beat = (remain <= LANES_VL);
    assign step      = last_beat ? remain : LANES_VL;

    // remain reaches zero once the final beat is taken, which closes the input.
    assign in_ready_o = (state == BUSY) && (remain != '0) && (!valid_q || out_ready_i);
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = valid_q && out_ready_i;

    always_ff @(posedge module_clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            op_q     <= '0;
            remain   <= '0;
            and_q    <= '0;
            or_q     <= '0;
            xor_q    <= '0;
            out_unit <= U_AND;
            be_q     <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q   <= op_i;
                        remain <= vl_i;
                        state  <= (vl_i != '0) ? BUSY : FINISH;
                    end
                end
                BUSY: begin
                    if (out_fire && last_q) state <= FINISH;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (in_fire) begin
                remain   <= remain - step;
                valid_q  <= 1'b1;
                last_q   <= last_beat;
                be_q     <= be_d;
                out_unit <= unit_sel;
                case (unit_sel)
                    U_OR:    or_q  <= or_d;
                    U_XOR:   xor_q <= xor_d;
                    default: and_q <= and_d;
                endcase
            end else if (out_fire) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        case (out_unit)
            U_OR:    result_o = or_q;
            U_XOR:   result_o = xor_q;
            default: result_o = and_q;
        endcase
    end

    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;
    assign out_be_o    = be_q;
    assign req_ready_o = (state == IDLE);
    assign done_o      = (state == FINISH);
    assign state_o     = state;

endmodule

// File: tb/tb_vlogic_lanes.sv
// Directed bench for vlogic_lanes: op-sweep table, tail masking, backpressure,
// vl=0, back-to-back requests and mid-operation reset.
module tb_vlogic_lanes;
    localparam int DW = 32;
    localparam int LN = 4;
    localparam int VW = 8;
    localparam int W  = DW * LN;
    localparam int EW = W + LN + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    op = '0;
    logic [VW-1:0] vl = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic [LN-1:0] out_be;
    logic          out_last;
    logic          done;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] exp;
    } op_vec_t;
    op_vec_t vecs[8];

    vlogic_lanes #(.DATA_WIDTH(DW), .LANES(LN), .VL_WIDTH(VW)) dut (
        .module_clk_i(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .op_i(op),
        .vl_i(vl),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .a_i(a),
        .b_i(b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o(result),
        .out_be_o(out_be),
        .out_last_o(out_last),
        .done_o(done),
        .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [W-1:0] rep(input logic [31:0] v);
        return {v, v, v, v};
    endfunction

    // Scoreboard: every output handshake must match the head of exp_q.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {result, out_be, out_last}, '0);
            end else begin
                check("out_beat", {result, out_be, out_last}, exp_q.pop_front());
            end
        end
    end

    task automatic do_req(input logic [2:0] o, input logic [VW-1:0] v);
        req_valid = 1'b1;
        op = o;
        vl = v;
        #1;
        check("req_ready_at_accept", EW'(req_ready), EW'(1));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [W-1:0] av, input logic [W-1:0] bv);
        bit taken = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        for (int i = 0; i < 20 && !taken; i++) begin
            #1;
            taken = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!taken) begin
            errors++;
            $display("FAIL send_beat_timeout in_ready stuck 0, required 1");
        end
    endtask

    task automatic push_exp(input logic [W-1:0] r, input logic [LN-1:0] be, input logic last);
        exp_q.push_back({r, be, last});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, EW'(req_ready), EW'(1));
        check({tag, "_in_ready"}, EW'(in_ready), EW'(0));
        check({tag, "_outs"}, {result, out_be, out_last}, '0);
        check({tag, "_valid_done"}, EW'({out_valid, done}), EW'(0));
    endtask

    initial begin
        vecs[0] = '{3'b000, 32'hF000F000};
        vecs[1] = '{3'b001, 32'h0FFF0FFF};
        vecs[2] = '{3'b010, 32'h0F000F00};
        vecs[3] = '{3'b011, 32'hFFF0FFF0};
        vecs[4] = '{3'b100, 32'h000F000F};
        vecs[5] = '{3'b101, 32'hFF0FFF0F};
        vecs[6] = '{3'b110, 32'h0FF00FF0};
        vecs[7] = '{3'b111, 32'hF00FF00F};

        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Op sweep: one full beat per op, done exactly one cycle after handshake.
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].op, 8'd4);
            push_exp(rep(vecs[i].exp), 4'b1111, 1'b1);
            send_beat(rep(32'hF0F0F0F0), rep(32'hFF00FF00));
            check("sweep_valid", EW'({out_valid, done}), EW'(2'b10));
            tick();
            check("sweep_done", EW'({done, out_valid}), EW'(2'b10));
            tick();
            check("sweep_idle", EW'({req_ready, done}), EW'(2'b10));
        end

        // Tail: vl=6 XOR, a = lane index, b = 0.
        do_req(3'b110, 8'd6);
        push_exp({32'd3, 32'd2, 32'd1, 32'd0}, 4'b1111, 1'b0);
        push_exp({32'd0, 32'd0, 32'd1, 32'd0}, 4'b0011, 1'b1);
        send_beat({32'd3, 32'd2, 32'd1, 32'd0}, '0);
        send_beat({32'd3, 32'd2, 32'd1, 32'd0}, '0);
        in_valid = 1'b1;
        #1;
        check("tail_third_refused", EW'(in_ready), EW'(0));
        tick();
        check("tail_done", EW'(done), EW'(1));
        #1;
        check("tail_finish_refused", EW'(in_ready), EW'(0));
        in_valid = 1'b0;
        tick();

        // Backpressure: vl=12 AND with all-ones a, stall 3 cycles on beat 1.
        do_req(3'b000, 8'd12);
        for (int n = 0; n < 3; n++) begin
            push_exp({DW'(n*16+3), DW'(n*16+2), DW'(n*16+1), DW'(n*16)}, 4'b1111, n == 2);
        end
        send_beat('1, {32'd3, 32'd2, 32'd1, 32'd0});
        send_beat('1, {32'd19, 32'd18, 32'd17, 32'd16});
        out_ready = 1'b0;
        in_valid = 1'b1;
        b = {32'd35, 32'd34, 32'd33, 32'd32};
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", EW'(in_ready), EW'(0));
            check("bp_hold", {result, out_be, out_valid}, {{32'd19, 32'd18, 32'd17, 32'd16}, 4'b1111, 1'b1});
            tick();
        end
        out_ready = 1'b1;
        send_beat('1, {32'd35, 32'd34, 32'd33, 32'd32});
        tick();
        check("bp_done", EW'(done), EW'(1));
        check("bp_drained", EW'(exp_q.size()), EW'(0));
        tick();

        // vl = 0: straight to completion, input never opens.
        do_req(3'b011, 8'd0);
        #1;
        check("vl0_done", EW'({done, in_ready}), EW'(2'b10));
        tick();
        #1;
        check("vl0_idle", EW'({req_ready, done, in_ready}), EW'(3'b100));

        // Back-to-back: second request held through BUSY, accepted only in IDLE.
        do_req(3'b011, 8'd8);
        req_valid = 1'b1;
        op = 3'b000;
        vl = 8'd4;
        #1;
        check("b2b_busy_ready", EW'(req_ready), EW'(0));
        push_exp(rep(32'h00FFFFFF), 4'b1111, 1'b0);
        push_exp(rep(32'h12345678), 4'b1111, 1'b1);
        send_beat(rep(32'h0000FFFF), rep(32'h00FF00FF));
        send_beat(rep(32'h12340000), rep(32'h00005678));
        tick();
        check("b2b_first_done", EW'({done, req_ready}), EW'(2'b10));
        tick();
        check("b2b_idle", EW'(req_ready), EW'(1));
        tick();
        req_valid = 1'b0;
        check("b2b_second_busy", EW'({req_ready, state}), EW'(3'b001));
        push_exp(rep(32'h0F0F0000), 4'b1111, 1'b1);
        send_beat(rep(32'hFFFF0000), rep(32'h0F0F0F0F));
        tick();
        check("b2b_second_done", EW'(done), EW'(1));
        tick();

        // Reset mid-BUSY with a result waiting: abort without done.
        out_ready = 1'b0;
        do_req(3'b110, 8'd8);
        send_beat(rep(32'hAAAA5555), rep(32'h0F0F0F0F));
        check("midrst_valid", EW'(out_valid), EW'(1));
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        check_reset_outputs("midrst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_done", EW'({done, out_valid, req_ready}), EW'(3'b001));
        end

        check("queue_drained", EW'(exp_q.size()), EW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not complete, required completion");
        $fatal(1);
    end

endmodule
